// File: rtl/tlvds_ddr_tx_ctrl.sv
// tlvds_ddr_tx_ctrl: sequencer feeding an ODDR (Q0 -> TLVDS_OBUF).
// Takes WIDTH-bit words on a valid/ready stream and presents them two bits
// per clk on d0/d1, LSB pair first. The idle pair is held through the ODDR
// warm-up and between frames.
// Optional feature: define LVDS_TX_PARITY_EN to append an even-parity beat
// (d0 = ^word, d1 = ~d0) to every frame.
module tlvds_ddr_tx_ctrl #(
  parameter int   WIDTH   = 8,
  parameter int   WARMUP  = 4,
  parameter logic IDLE_D0 = 1'b0,
  parameter logic IDLE_D1 = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic             d0,
  output logic             d1,
  output logic             busy,
  output logic             frame_done
);

  localparam int NB = WIDTH / 2;
`ifdef LVDS_TX_PARITY_EN
  localparam int NBT = NB + 1;
`else
  localparam int NBT = NB;
`endif
  localparam int BC_W = $clog2(NB + 1);
  localparam int WC_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WC_W-1:0] WARM_LAST = (WARMUP > 0) ? WC_W'(WARMUP - 1) : '0;
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(NBT - 1);

  typedef enum logic [1:0] {WARM, IDLE, SHIFT} state_t;

  state_t           state_q, state_nx;
  logic [WC_W-1:0]  warm_q, warm_nx;
  logic [BC_W-1:0]  beat_q, beat_nx, beat_inc;
  logic [WIDTH-1:0] shreg_q, shreg_nx;
  logic             ready_nx, d0_nx, d1_nx, busy_nx, done_nx;
  logic             load;
`ifdef LVDS_TX_PARITY_EN
  logic             par_q, par_nx;
`endif

  // State, counters and all registered outputs; reset aborts any frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WARM;
      warm_q     <= '0;
      beat_q     <= '0;
      shreg_q    <= '0;
      s_ready    <= 1'b0;
      d0         <= IDLE_D0;
      d1         <= IDLE_D1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef LVDS_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_nx;
      warm_q     <= warm_nx;
      beat_q     <= beat_nx;
      shreg_q    <= shreg_nx;
      s_ready    <= ready_nx;
      d0         <= d0_nx;
      d1         <= d1_nx;
      busy       <= busy_nx;
      frame_done <= done_nx;
`ifdef LVDS_TX_PARITY_EN
      par_q      <= par_nx;
`endif
    end
  end

  // Next state and next output values. Outputs are computed one cycle ahead
  // so that the beat shown after an edge is registered, not combinational.
  always_comb begin
    state_nx = state_q;
    warm_nx  = warm_q;
    beat_nx  = beat_q;
    shreg_nx = shreg_q;
    ready_nx = 1'b0;
    d0_nx    = IDLE_D0;
    d1_nx    = IDLE_D1;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    load     = 1'b0;
    beat_inc = beat_q + BC_W'(1);
`ifdef LVDS_TX_PARITY_EN
    par_nx   = par_q;
`endif
    case (state_q)
      WARM: begin
        if (WARMUP == 0 || warm_q == WARM_LAST) begin
          state_nx = IDLE;
          ready_nx = 1'b1;
        end else begin
          warm_nx = warm_q + WC_W'(1);
        end
      end
      IDLE: begin
        if (s_valid && s_ready) load = 1'b1;
        else                    ready_nx = 1'b1;
      end
      SHIFT: begin
        if (beat_q == LAST_BEAT) begin
          if (s_valid && s_ready) begin
            load = 1'b1;
          end else begin
            state_nx = IDLE;
            ready_nx = 1'b1;
          end
        end else begin
          beat_nx  = beat_inc;
          busy_nx  = 1'b1;
          ready_nx = (beat_inc == LAST_BEAT);
          done_nx  = (beat_inc == LAST_BEAT);
`ifdef LVDS_TX_PARITY_EN
          if (beat_inc == BC_W'(NB)) begin
            d0_nx = par_q;
            d1_nx = ~par_q;
          end else
`endif
          begin
            d0_nx    = shreg_q[0];
            d1_nx    = shreg_q[1];
            shreg_nx = shreg_q >> 2;
          end
        end
      end
      default: state_nx = WARM;
    endcase

    // Accept: beat 0 goes straight to the output registers, the rest waits.
    if (load) begin
      state_nx = SHIFT;
      beat_nx  = '0;
      shreg_nx = s_data >> 2;
      d0_nx    = s_data[0];
      d1_nx    = s_data[1];
      busy_nx  = 1'b1;
      ready_nx = (NBT == 1);
      done_nx  = (NBT == 1);
`ifdef LVDS_TX_PARITY_EN
      par_nx   = ^s_data;
`endif
    end
  end

endmodule
